// File: rtl/wishbone_uart_rx_fifo_slave.sv
// Wishbone classic slave that queues bytes from a UART receiver in a FIFO.
// The master pops bytes through RXDATA, polls STATUS and flushes or clears the overrun flag through CONTROL.
module wishbone_uart_rx_fifo_slave #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] data_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_data_valid_i,
  output logic        rx_data_ready_o,
  output logic        irq_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = 1;

  localparam logic [1:0] ADDR_RXDATA  = 2'b00;
  localparam logic [1:0] ADDR_STATUS  = 2'b01;
  localparam logic [1:0] ADDR_CONTROL = 2'b10;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overrun;
  logic                  r_ack;
  logic [31:0]           r_data;
  logic                  r_ready;

  logic        w_req;
  logic [1:0]  w_sel;
  logic        w_notEmpty;
  logic        w_full;
  logic        w_pop;
  logic        w_flush;
  logic        w_clrOvr;
  logic        w_pushReq;
  logic        w_push;
  logic        w_overflow;
  logic [7:0]  w_countByte;
  logic [31:0] w_rdData;
  logic        w_unused;

  assign w_unused = ^{addr_i[31:4], addr_i[1:0], data_i[31:2]};

  // A request is accepted only on the edge that raises ack, so each transfer has exactly one side effect.
  assign w_req      = cyc_i & stb_i & ~r_ack;
  assign w_sel      = addr_i[3:2];
  assign w_notEmpty = (r_count != '0);
  assign w_full     = (r_count == FULL_COUNT);
  assign w_pop      = w_req & ~we_i & (w_sel == ADDR_RXDATA) & w_notEmpty;
  assign w_flush    = w_req & we_i & (w_sel == ADDR_CONTROL) & data_i[1];
  assign w_clrOvr   = w_req & we_i & (w_sel == ADDR_CONTROL) & data_i[0];
  assign w_pushReq  = rx_data_valid_i & r_ready;
  // A pop on the same edge frees a slot, so a full FIFO can still accept the byte.
  assign w_push     = w_pushReq & (~w_full | w_pop) & ~w_flush;
  assign w_overflow = w_pushReq & w_full & ~w_pop & ~w_flush;
  assign w_countByte = 8'(r_count);

  always_comb begin
    w_rdData = '0;
    if (!we_i) begin
      case (w_sel)
        ADDR_RXDATA: if (w_notEmpty) w_rdData = {24'h0, r_mem[r_rdPtr]};
        ADDR_STATUS: w_rdData = {16'h0, w_countByte, 5'h0, r_overrun, w_full, w_notEmpty};
        default:     w_rdData = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wrPtr] <= rx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack     <= 1'b0;
      r_data    <= '0;
      r_ready   <= 1'b0;
      r_rdPtr   <= '0;
      r_wrPtr   <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_ack   <= w_req;
      r_data  <= w_req ? w_rdData : '0;
      r_ready <= 1'b1;
      if (w_flush) begin
        r_rdPtr <= '0;
        r_wrPtr <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
        if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
        if (w_push && !w_pop)      r_count <= r_count + COUNT_ONE;
        else if (w_pop && !w_push) r_count <= r_count - COUNT_ONE;
      end
      // Setting wins over clearing when both land on the same edge.
      if (w_overflow)    r_overrun <= 1'b1;
      else if (w_clrOvr) r_overrun <= 1'b0;
    end
  end

  assign ack_o           = r_ack;
  assign data_o          = r_data;
  assign rx_data_ready_o = r_ready;
  assign irq_o           = w_notEmpty;

endmodule

// File: tb/tb_wishbone_uart_rx_fifo_slave.sv
// Directed self-checking bench for wishbone_uart_rx_fifo_slave (depth 16).
module tb_wishbone_uart_rx_fifo_slave;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] data_i;
  logic        cyc_i;
  logic        stb_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic [7:0]  rx_data_i;
  logic        rx_data_valid_i;
  logic        rx_data_ready_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_RXDATA  = 32'h0;
  localparam logic [31:0] A_STATUS  = 32'h4;
  localparam logic [31:0] A_CONTROL = 32'h8;
  localparam logic [31:0] A_UNMAP   = 32'hC;

  wishbone_uart_rx_fifo_slave #(.DEPTH_LOG2(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .we_i(we_i), .data_i(data_i),
    .cyc_i(cyc_i), .stb_i(stb_i), .data_o(data_o), .ack_o(ack_o),
    .rx_data_i(rx_data_i), .rx_data_valid_i(rx_data_valid_i),
    .rx_data_ready_o(rx_data_ready_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Starts a transfer, waits a bounded number of cycles for ack, then lets ack fall.
  task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic push, input logic [7:0] pushByte, output logic [31:0] rdata);
    bit gotAck = 0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = write; addr_i = addr; data_i = wdata;
    rx_data_valid_i = push; rx_data_i = pushByte;
    for (int i = 0; i < 4 && !gotAck; i++) begin
      tick();
      rx_data_valid_i = 1'b0;
      gotAck = (ack_o === 1'b1);
    end
    rdata = data_o;
    if (!gotAck) checkOutput("ack timeout", {31'h0, ack_o}, 32'h1);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    tick();
  endtask

  task automatic pushByte(input logic [7:0] b);
    rx_data_i = b; rx_data_valid_i = 1'b1;
    tick();
    rx_data_valid_i = 1'b0;
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] rdata);
    applyStimulus(1'b0, addr, 32'h0, 1'b0, 8'h0, rdata);
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    applyStimulus(1'b1, addr, wdata, 1'b0, 8'h0, dummy);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  expQ [$];
    int          ackCount;
    rst_i = 1'b1; addr_i = '0; we_i = 1'b0; data_i = '0; cyc_i = 1'b0; stb_i = 1'b0;
    rx_data_i = '0; rx_data_valid_i = 1'b0;
    repeat (3) tick();
    checkOutput("reset ack", {31'h0, ack_o}, 32'h0);
    checkOutput("reset data", data_o, 32'h0);
    checkOutput("reset ready", {31'h0, rx_data_ready_o}, 32'h0);
    checkOutput("reset irq", {31'h0, irq_o}, 32'h0);
    rst_i = 1'b0;
    tick();
    checkOutput("ready after reset", {31'h0, rx_data_ready_o}, 32'h1);

    $display("[TB] single byte");
    pushByte(8'hA5);
    checkOutput("irq after push", {31'h0, irq_o}, 32'h1);
    readReg(A_STATUS, rd);
    checkOutput("status one byte", rd, 32'h0000_0101);
    readReg(A_RXDATA, rd);
    checkOutput("rxdata A5", rd, 32'h0000_00A5);
    checkOutput("irq after pop", {31'h0, irq_o}, 32'h0);
    checkOutput("data idle", data_o, 32'h0);

    $display("[TB] fill and overrun");
    for (int i = 1; i <= 16; i++) pushByte(8'(i));
    readReg(A_STATUS, rd);
    checkOutput("status full", rd, 32'h0000_1003);
    pushByte(8'h11);
    readReg(A_STATUS, rd);
    checkOutput("status overrun", rd, 32'h0000_1007);
    for (int i = 1; i <= 16; i++) begin
      readReg(A_RXDATA, rd);
      checkOutput("drain order", rd, 32'(i));
    end
    readReg(A_STATUS, rd);
    checkOutput("status drained sticky", rd, 32'h0000_0004);
    writeReg(A_CONTROL, 32'h1);
    readReg(A_STATUS, rd);
    checkOutput("status overrun cleared", rd, 32'h0000_0000);

    $display("[TB] push and pop on full");
    for (int i = 0; i < 16; i++) pushByte(8'h20 + 8'(i));
    applyStimulus(1'b0, A_RXDATA, 32'h0, 1'b1, 8'h55, rd);
    checkOutput("pop while push", rd, 32'h0000_0020);
    readReg(A_STATUS, rd);
    checkOutput("status full no overrun", rd, 32'h0000_1003);
    for (int i = 1; i < 16; i++) expQ.push_back(8'h20 + 8'(i));
    expQ.push_back(8'h55);
    for (int i = 0; i < 16; i++) begin
      readReg(A_RXDATA, rd);
      checkOutput("wrap order", rd, {24'h0, expQ[i]});
    end

    $display("[TB] empty read and overrun clear");
    readReg(A_RXDATA, rd);
    checkOutput("empty rxdata", rd, 32'h0);
    readReg(A_STATUS, rd);
    checkOutput("status empty", rd, 32'h0);
    readReg(A_UNMAP, rd);
    checkOutput("unmapped read", rd, 32'h0);
    for (int i = 0; i < 17; i++) pushByte(8'h40 + 8'(i));
    readReg(A_CONTROL, rd);
    checkOutput("control read", rd, 32'h0);
    writeReg(A_CONTROL, 32'h1);
    readReg(A_STATUS, rd);
    checkOutput("status after clear", rd, 32'h0000_1003);
    applyStimulus(1'b1, A_CONTROL, 32'h1, 1'b1, 8'h99, rd);
    readReg(A_STATUS, rd);
    checkOutput("clear vs overflow", rd, 32'h0000_1007);
    writeReg(A_CONTROL, 32'h3);
    readReg(A_STATUS, rd);
    checkOutput("flush and clear", rd, 32'h0);

    $display("[TB] flush with push");
    for (int i = 0; i < 5; i++) pushByte(8'h30 + 8'(i));
    readReg(A_STATUS, rd);
    checkOutput("status five", rd, 32'h0000_0501);
    applyStimulus(1'b1, A_CONTROL, 32'h2, 1'b1, 8'h77, rd);
    checkOutput("irq after flush", {31'h0, irq_o}, 32'h0);
    readReg(A_STATUS, rd);
    checkOutput("status after flush", rd, 32'h0);
    pushByte(8'h3C);
    readReg(A_RXDATA, rd);
    checkOutput("byte after flush", rd, 32'h0000_003C);

    $display("[TB] held strobe and reset");
    for (int i = 0; i < 4; i++) pushByte(8'h61 + 8'(i));
    ackCount = 0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = A_RXDATA;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack_o === 1'b1) begin
        checkOutput("held pop data", data_o, 32'h61 + 32'(ackCount));
        ackCount++;
      end else begin
        checkOutput("held idle data", data_o, 32'h0);
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    checkOutput("held ack pulses", 32'(ackCount), 32'd3);
    tick();
    readReg(A_STATUS, rd);
    checkOutput("status after held", rd, 32'h0000_0101);
    pushByte(8'h70);
    pushByte(8'h71);
    cyc_i = 1'b1; stb_i = 1'b1; addr_i = A_RXDATA;
    tick();
    checkOutput("ack before reset", {31'h0, ack_o}, 32'h1);
    rst_i = 1'b1;
    tick();
    checkOutput("ack after reset", {31'h0, ack_o}, 32'h0);
    checkOutput("irq after reset", {31'h0, irq_o}, 32'h0);
    rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
    tick();
    readReg(A_STATUS, rd);
    checkOutput("status after reset", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
